fifo_stream: RTL and testbench

Downstream drain stage for the block-RAM FIFO. It issues FIFO reads, absorbs the fixed read latency of the RAM, and presents the words as a valid/ready stream with a small skid buffer. It sustains one word per clock when the consumer is always ready, and never over-reads the FIFO.

---
 rtl/utils_pkg.sv | 11 +
 rtl/fifo_stream_regfifo.sv | 63 ++++++
 rtl/fifo_stream.sv | 73 +++++++
 tb/tb_fifo_stream.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/utils_pkg.sv
// Shared helpers for the FIFO drain path: counter-width function and the RAM latency limit.
package utils_pkg;

  localparam int FIFO_LAT_MAX = 2;

  // Never returns 0, so a 1-entry structure still gets a 1-bit pointer.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fifo_stream_regfifo.sv
// Small in-order register FIFO; dout is the head entry and registered writes appear the next cycle.
// Push while full is only accepted together with a pop; pop while empty is ignored.
module regfifo
  import utils_pkg::*;
#(
  parameter int DATA_  = 8,
  parameter int DEPTH_ = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic [DATA_-1:0]             din_i,
  output logic [DATA_-1:0]             dout_o,
  output logic [$clog2(DEPTH_+1)-1:0]  level_o
);
  localparam int PW = clog2_min1(DEPTH_);
  localparam int LW = $clog2(DEPTH_ + 1);

  logic [DATA_-1:0] mem_q [DEPTH_];
  logic [PW-1:0]    rd_q, rd_d;
  logic [PW-1:0]    wr_q, wr_d;
  logic [LW-1:0]    lvl_q, lvl_d;
  logic             do_push, do_pop;

  // Depth need not be a power of two, so pointers wrap explicitly.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH_ - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    rd_d    = rd_q;
    wr_d    = wr_q;
    lvl_d   = lvl_q;
    do_pop  = pop_i && (lvl_q != '0);
    do_push = push_i && ((lvl_q != LW'(DEPTH_)) || do_pop);
    if (do_pop)  rd_d = ptr_inc(rd_q);
    if (do_push) wr_d = ptr_inc(wr_q);
    case ({do_push, do_pop})
      2'b10:   lvl_d = lvl_q + LW'(1);
      2'b01:   lvl_d = lvl_q - LW'(1);
      default: lvl_d = lvl_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      lvl_q <= '0;
      for (int i = 0; i < DEPTH_; i++) mem_q[i] <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      lvl_q <= lvl_d;
      if (do_push) mem_q[wr_q] <= din_i;
    end
  end

  assign dout_o  = mem_q[rd_q];
  assign level_o = lvl_q;

endmodule

// File: rtl/fifo_stream.sv
// Drains a block-RAM FIFO into a valid/ready stream; first word appears LAT_+1 cycles after fifo_re.
// Backpressure: reads stop once buffered plus in-flight words fill the LAT_+1 entry skid buffer.
module fifo_stream
  import utils_pkg::*;
#(
  parameter int DATA_ = 8,
  parameter int LAT_  = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       fifo_empty,
  output logic                       fifo_re,
  input  logic [DATA_-1:0]           fifo_dout,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [DATA_-1:0]           m_data,
  output logic [$clog2(LAT_+2)-1:0]  level
);
  localparam int DEPTH = LAT_ + 1;
  localparam int LW    = $clog2(LAT_ + 2);
  localparam int CW    = LW + 1;

  if (!(LAT_ inside {1, 2}) || (LAT_ > FIFO_LAT_MAX)) begin : g_lat_check
    $error("fifo_stream: LAT_ must be 1 or 2");
  end

  logic [LAT_-1:0]  ret_vld_q, ret_vld_d;
  logic [CW-1:0]    pending;
  logic [CW-1:0]    credit;
  logic [LW-1:0]    buf_level;
  logic [DATA_-1:0] buf_dout;
  logic             push, pop;

  assign push    = ret_vld_q[LAT_-1];
  assign pop     = m_valid && m_ready;
  assign m_valid = (buf_level != '0);
  assign level   = buf_level;
  assign m_data  = buf_dout;

  // A read is issued only if its word is guaranteed a slot when it lands.
  always_comb begin
    pending = '0;
    for (int i = 0; i < LAT_; i++) pending = pending + CW'(ret_vld_q[i]);
    credit    = CW'(buf_level) + pending - CW'(pop);
    fifo_re   = !rst && !fifo_empty && (credit < CW'(DEPTH));
    ret_vld_d = (ret_vld_q << 1) | LAT_'(fifo_re);
  end

  always_ff @(posedge clk) begin
    if (rst) ret_vld_q <= '0;
    else     ret_vld_q <= ret_vld_d;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(push && (buf_level == LW'(DEPTH))));
    end
  end

  regfifo #(
    .DATA_  (DATA_),
    .DEPTH_ (DEPTH)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (fifo_dout),
    .dout_o  (buf_dout),
    .level_o (buf_level)
  );

endmodule

// File: tb/tb_fifo_stream.sv
// Bench for fifo_stream: LAT_=1 instance for the cycle table, LAT_=2 instance for stream sequences.
module tb_fifo_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // Instance 0: LAT_=1
  logic       empty0, re0, mv0, mr0;
  logic [7:0] dout0, md0;
  logic [1:0] lvl0;
  // Instance 1: LAT_=2
  logic       empty1, re1, mv1, mr1;
  logic [7:0] dout1, md1;
  logic [1:0] lvl1;

  fifo_stream #(.DATA_(8), .LAT_(1)) dut0 (
    .clk(clk), .rst(rst), .fifo_empty(empty0), .fifo_re(re0), .fifo_dout(dout0),
    .m_valid(mv0), .m_ready(mr0), .m_data(md0), .level(lvl0)
  );

  fifo_stream #(.DATA_(8), .LAT_(2)) dut1 (
    .clk(clk), .rst(rst), .fifo_empty(empty1), .fifo_re(re1), .fifo_dout(dout1),
    .m_valid(mv1), .m_ready(mr1), .m_data(md1), .level(lvl1)
  );

  // Block-RAM FIFO models with 1 and 2 cycle read latency.
  logic [7:0] mem0 [256];
  logic [7:0] mem1 [256];
  int wr0 = 0, rd0 = 0, wr1 = 0, rd1 = 0;
  logic [7:0] p0, p1a, p1b;

  assign empty0 = (rd0 == wr0);
  assign empty1 = (rd1 == wr1);
  assign dout0  = p0;
  assign dout1  = p1b;

  always @(posedge clk) begin
    if (re0) begin
      p0  <= mem0[rd0[7:0]];
      rd0 <= rd0 + 1;
    end
  end

  always @(posedge clk) begin
    p1b <= p1a;
    if (re1) begin
      p1a <= mem1[rd1[7:0]];
      rd1 <= rd1 + 1;
    end
  end

  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  logic [7:0] exp1[$];

  task automatic push1(input logic [7:0] v);
    mem1[wr1[7:0]] = v;
    wr1 = wr1 + 1;
    exp1.push_back(v);
  endtask

  // Scoreboard and protocol monitor for instance 1.
  logic       sb_en = 1'b0;
  logic       stall_prev = 1'b0;
  logic [7:0] data_prev = '0;
  int         h1 = 0, h2 = 0;
  int         n_pop1 = 0;

  always @(negedge clk) begin
    if (sb_en && !rst) begin
      if (stall_prev) begin
        chk("hold_valid", int'(mv1), 1);
        chk("hold_data", int'(md1), int'(data_prev));
      end
      if (empty1) chk("read_while_empty", int'(re1), 0);
      chk("credit_bound",
          ((int'(lvl1) + h1 + h2 + int'(re1) - int'(mv1 && mr1)) <= 3) ? 1 : 0, 1);
      if (mv1 && mr1) begin
        if (exp1.size() == 0) begin
          n_cmp++;
          n_mis++;
          $display("FAIL extra_word: got 0x%0h, expected no word (t=%0t)", md1, $time);
        end else begin
          chk("stream_order", int'(md1), int'(exp1.pop_front()));
        end
        n_pop1++;
      end
    end
    stall_prev = mv1 && !mr1 && !rst;
    data_prev  = md1;
    h2 = h1;
    h1 = int'(re1);
  end

  typedef struct {
    logic       rdy;
    logic       re;
    logic       vld;
    logic [7:0] dat;
    logic [1:0] lvl;
  } vec_t;

  vec_t tbl [20];

  initial begin
    int cnt;
    int base;
    int n;

    // LAT_=1 stream of 0x01..0x10: reads in cycles 0..15, words out in cycles 2..17.
    for (int c = 0; c < 20; c++) begin
      tbl[c].rdy = 1'b1;
      tbl[c].re  = (c <= 15);
      tbl[c].vld = (c >= 2) && (c <= 17);
      tbl[c].dat = tbl[c].vld ? 8'(c - 1) : 8'h00;
      tbl[c].lvl = tbl[c].vld ? 2'd1 : 2'd0;
    end

    rst = 1'b1;
    mr0 = 1'b1;
    mr1 = 1'b0;
    for (int i = 0; i < 16; i++) mem0[i] = 8'(i + 1);
    wr0 = 16;

    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_re0", int'(re0), 0);
    chk("rst_valid0", int'(mv0), 0);
    chk("rst_level0", int'(lvl0), 0);
    chk("rst_data0", int'(md0), 0);
    chk("rst_valid1", int'(mv1), 0);
    chk("rst_level1", int'(lvl1), 0);
    chk("rst_re1", int'(re1), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int c = 0; c < 20; c++) begin
      mr0 = tbl[c].rdy;
      @(negedge clk);
      chk($sformatf("tbl_re[%0d]", c), int'(re0), int'(tbl[c].re));
      chk($sformatf("tbl_valid[%0d]", c), int'(mv0), int'(tbl[c].vld));
      chk($sformatf("tbl_level[%0d]", c), int'(lvl0), int'(tbl[c].lvl));
      if (tbl[c].vld) chk($sformatf("tbl_data[%0d]", c), int'(md0), int'(tbl[c].dat));
      @(posedge clk);
      #1;
    end

    sb_en = 1'b1;

    // Trickle: one word every 5 cycles, visible LAT_+1 = 3 cycles after the FIFO goes non-empty.
    mr1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      push1(8'hC0 + 8'(k));
      for (int d = 0; d < 5; d++) begin
        @(negedge clk);
        if (d == 0) chk("trickle_re", int'(re1), 1);
        chk($sformatf("trickle_valid[%0d.%0d]", k, d), int'(mv1), (d == 3) ? 1 : 0);
        if (d == 3) chk("trickle_data", int'(md1), int'(8'hC0) + k);
        @(posedge clk);
        #1;
      end
    end

    // 64 words under roughly 30% random stalls.
    base = n_pop1;
    for (int i = 0; i < 64; i++) push1(8'(i * 7 + 3));
    n = 0;
    while (exp1.size() != 0 && n < 2000) begin
      mr1 = ($urandom_range(0, 99) >= 30);
      @(posedge clk);
      #1;
      n++;
    end
    mr1 = 1'b1;
    chk("bp_drained", exp1.size(), 0);
    chk("bp_count", n_pop1 - base, 64);

    // Stall for 10 cycles mid-stream, then resume.
    for (int i = 0; i < 40; i++) push1(8'h80 + 8'(i));
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    mr1 = 1'b0;
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      cnt += int'(re1);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("stall_reads_le_depth", (cnt <= 3) ? 1 : 0, 1);
    chk("stall_re_off", int'(re1), 0);
    chk("stall_level", int'(lvl1), 3);
    @(posedge clk);
    #1;
    mr1 = 1'b1;
    @(negedge clk);
    chk("resume_re", int'(re1), 1);
    for (int i = 0; i < 15; i++) begin
      chk($sformatf("resume_no_gap[%0d]", i), int'(mv1), 1);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    n = 0;
    while (exp1.size() != 0 && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("stall_drained", exp1.size(), 0);

    // Reset with 2 words buffered and 1 returning.
    mr1 = 1'b0;
    push1(8'h70);
    push1(8'h71);
    push1(8'h72);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    exp1.delete();
    wr1 = rd1;
    @(negedge clk);
    chk("prerst_level", int'(lvl1), 2);
    chk("prerst_valid", int'(mv1), 1);
    chk("prerst_data", int'(md1), 'h70);
    chk("rst_gates_re", int'(re1), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("postrst_valid[%0d]", i), int'(mv1), 0);
      chk($sformatf("postrst_level[%0d]", i), int'(lvl1), 0);
      @(posedge clk);
      #1;
    end
    base = n_pop1;
    mr1 = 1'b1;
    for (int i = 0; i < 4; i++) push1(8'hA0 + 8'(i));
    n = 0;
    while (exp1.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    repeat (6) begin
      @(posedge clk);
      #1;
    end
    chk("reload_drained", exp1.size(), 0);
    chk("reload_count", n_pop1 - base, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
